// File: rtl/oflow_fsm_buffer_write.sv
// Write-side control FSM of the oflow MEM buffer: picks the frame's history slot,
// latches its bbox count and steps a pair of write offsets per core handshake.
module oflow_fsm_buffer_write #(
    parameter int TOTAL_FRAME_NUM_WIDTH       = 8,
    parameter int NUM_OF_HISTORY_FRAMES_WIDTH = 3,
    parameter int ADDR_WIDTH                  = 8,
    parameter int OFFSET_WIDTH                = 8,
    parameter int NUM_SLOTS                   = 5
) (
    input  logic                                   clk,
    input  logic                                   reset_N,
    input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num,
    input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
    input  logic [ADDR_WIDTH-1:0]                  end_pointers [NUM_SLOTS],
    input  logic                                   start_write,
    input  logic                                   ready_from_core,
    output logic                                   done_write,
    output logic [OFFSET_WIDTH-1:0]                offset_0,
    output logic [OFFSET_WIDTH-1:0]                offset_1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [OFFSET_WIDTH-1:0] count_r;
    logic [OFFSET_WIDTH-1:0] count_nxt_s;
    logic [OFFSET_WIDTH-1:0] offset_0_nxt_s;
    logic [OFFSET_WIDTH-1:0] offset_1_nxt_s;
    logic                    done_nxt_s;
    logic [2:0]              hist_clamped_s;
    logic [2:0]              slot_s;
    logic [OFFSET_WIDTH-1:0] count_sel_s;
    logic                    last_pair_s;

    // Clamp the history depth to the legal 1..5 range.
    always_comb begin
        hist_clamped_s = 3'd1;
        if (num_of_history_frames == NUM_OF_HISTORY_FRAMES_WIDTH'(0)) begin
            hist_clamped_s = 3'd1;
        end else if (num_of_history_frames > NUM_OF_HISTORY_FRAMES_WIDTH'(5)) begin
            hist_clamped_s = 3'd5;
        end else begin
            hist_clamped_s = 3'(num_of_history_frames);
        end
    end

    // Slot index = frame_num mod depth; constant divisors keep the modulo cheap.
    always_comb begin
        slot_s = 3'd0;
        case (hist_clamped_s)
            3'd1:    slot_s = 3'd0;
            3'd2:    slot_s = 3'(frame_num % TOTAL_FRAME_NUM_WIDTH'(2));
            3'd3:    slot_s = 3'(frame_num % TOTAL_FRAME_NUM_WIDTH'(3));
            3'd4:    slot_s = 3'(frame_num % TOTAL_FRAME_NUM_WIDTH'(4));
            3'd5:    slot_s = 3'(frame_num % TOTAL_FRAME_NUM_WIDTH'(5));
            default: slot_s = 3'd0;
        endcase
    end

    assign count_sel_s = OFFSET_WIDTH'(end_pointers[slot_s]);

    // One bit of headroom so offset_0+2 cannot wrap before the compare.
    assign last_pair_s = ({1'b0, offset_0} + (OFFSET_WIDTH+1)'(2)) >= {1'b0, count_r};

    // Next-state, latched count, offsets and done pulse.
    always_comb begin
        state_nxt_s    = state_r;
        count_nxt_s    = count_r;
        offset_0_nxt_s = offset_0;
        offset_1_nxt_s = offset_1;
        done_nxt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_write) begin
                    count_nxt_s    = count_sel_s;
                    offset_0_nxt_s = OFFSET_WIDTH'(0);
                    offset_1_nxt_s = OFFSET_WIDTH'(1);
                    if (count_sel_s == OFFSET_WIDTH'(0)) begin
                        state_nxt_s = DONE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = WRITE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WRITE: begin
                if (ready_from_core) begin
                    if (last_pair_s) begin
                        state_nxt_s = DONE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        offset_0_nxt_s = offset_0 + OFFSET_WIDTH'(2);
                        offset_1_nxt_s = offset_1 + OFFSET_WIDTH'(2);
                    end
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            DONE: begin
                state_nxt_s    = IDLE;
                offset_0_nxt_s = OFFSET_WIDTH'(0);
                offset_1_nxt_s = OFFSET_WIDTH'(1);
            end
            default: begin
                state_nxt_s    = IDLE;
                offset_0_nxt_s = OFFSET_WIDTH'(0);
                offset_1_nxt_s = OFFSET_WIDTH'(1);
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_r    <= IDLE;
            count_r    <= OFFSET_WIDTH'(0);
            offset_0   <= OFFSET_WIDTH'(0);
            offset_1   <= OFFSET_WIDTH'(1);
            done_write <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            count_r    <= count_nxt_s;
            offset_0   <= offset_0_nxt_s;
            offset_1   <= offset_1_nxt_s;
            done_write <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_oflow_fsm_buffer_write.sv
// Directed plus randomized bench; expected offsets come from the pair-list rule
// (pair k = (2k, 2k+1), ceil(count/2) pairs) and the clamped slot lookup.
module tb_oflow_fsm_buffer_write;

    localparam int FW = 8;
    localparam int HW = 3;
    localparam int AW = 8;
    localparam int OW = 8;
    localparam int NS = 5;

    logic          clk = 1'b0;
    logic          reset_N;
    logic [FW-1:0] frame_num;
    logic [HW-1:0] num_of_history_frames;
    logic [AW-1:0] end_pointers [NS];
    logic          start_write;
    logic          ready_from_core;
    logic          done_write;
    logic [OW-1:0] offset_0;
    logic [OW-1:0] offset_1;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    oflow_fsm_buffer_write #(
        .TOTAL_FRAME_NUM_WIDTH      (FW),
        .NUM_OF_HISTORY_FRAMES_WIDTH(HW),
        .ADDR_WIDTH                 (AW),
        .OFFSET_WIDTH               (OW),
        .NUM_SLOTS                  (NS)
    ) dut (
        .clk                  (clk),
        .reset_N              (reset_N),
        .frame_num            (frame_num),
        .num_of_history_frames(num_of_history_frames),
        .end_pointers         (end_pointers),
        .start_write          (start_write),
        .ready_from_core      (ready_from_core),
        .done_write           (done_write),
        .offset_0             (offset_0),
        .offset_1             (offset_1)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int d, input int o0);
        check({tag, ".done"}, 32'(done_write), 32'(d));
        check({tag, ".off0"}, 32'(offset_0), 32'(o0));
        check({tag, ".off1"}, 32'(offset_1), 32'(o0 + 1));
    endtask

    function automatic int model_count(input int fn, input int nh);
        int n;
        n = (nh < 1) ? 1 : ((nh > 5) ? 5 : nh);
        return int'(end_pointers[fn % n]);
    endfunction

    task automatic set_eps(input int e0, input int e1, input int e2, input int e3, input int e4);
        end_pointers[0] = AW'(e0);
        end_pointers[1] = AW'(e1);
        end_pointers[2] = AW'(e2);
        end_pointers[3] = AW'(e3);
        end_pointers[4] = AW'(e4);
    endtask

    task automatic handshake(input int k, input int gap, input bit last, input bit inject);
        for (int g = 0; g < gap; g++) begin
            if (inject && g == 0) begin
                start_write = 1'b1;
            end
            step();
            start_write = 1'b0;
            expect_out("hold", 0, 2 * k);
        end
        ready_from_core = 1'b1;
        step();
        ready_from_core = 1'b0;
        if (last) begin
            expect_out("done", 1, 2 * k);
            step();
            expect_out("back_idle", 0, 0);
        end else begin
            expect_out("advance", 0, 2 * k + 2);
        end
    endtask

    task automatic run_frame(input int fn, input int nh, input int gap,
                             input bit scramble, input bit inject, input bit with_ready);
        int cnt;
        int pairs;
        frame_num             = FW'(fn);
        num_of_history_frames = HW'(nh);
        cnt                   = model_count(fn, nh);
        start_write           = 1'b1;
        ready_from_core       = with_ready;
        step();
        start_write     = 1'b0;
        ready_from_core = 1'b0;
        if (scramble) begin
            frame_num = FW'($urandom);
            for (int i = 0; i < NS; i++) end_pointers[i] = AW'($urandom_range(0, 40));
        end
        if (cnt == 0) begin
            expect_out("start_zero", 1, 0);
            step();
            expect_out("zero_idle", 0, 0);
        end else begin
            expect_out("start", 0, 0);
            pairs = (cnt + 1) / 2;
            for (int k = 0; k < pairs; k++) begin
                handshake(k, gap, k == pairs - 1, inject && k == 0);
            end
        end
    endtask

    task automatic idle_ready(input int n);
        for (int i = 0; i < n; i++) begin
            ready_from_core = 1'b1;
            step();
            ready_from_core = 1'b0;
            step();
            expect_out("idle_ready", 0, 0);
        end
    endtask

    initial begin
        reset_N               = 1'b0;
        start_write           = 1'b0;
        ready_from_core       = 1'b0;
        frame_num             = '0;
        num_of_history_frames = '0;
        set_eps(0, 0, 0, 0, 0);
        repeat (2) step();
        expect_out("reset", 0, 0);
        reset_N = 1'b1;
        step();
        expect_out("post_reset", 0, 0);

        // Slot 12 % 4 = 0, odd count 9, ready every 4 cycles, then stray readies.
        set_eps(9, 0, 0, 0, 0);
        run_frame(12, 4, 3, 1'b0, 1'b0, 1'b0);
        idle_ready(27);

        // Even count: 7 % 5 = 2; inputs scrambled after start and a stray start in WRITE.
        set_eps(0, 0, 4, 0, 0);
        run_frame(7, 5, 2, 1'b1, 1'b1, 1'b0);

        // Zero count in the selected slot.
        set_eps(0, 6, 6, 6, 6);
        run_frame(10, 5, 1, 1'b0, 1'b0, 1'b0);

        // Depth 0 clamps to 1; depth 7 clamps to 5 (13 % 5 = 3).
        set_eps(2, 7, 7, 7, 7);
        run_frame(3, 0, 1, 1'b0, 1'b0, 1'b0);
        set_eps(1, 1, 1, 5, 1);
        run_frame(13, 7, 0, 1'b0, 1'b0, 1'b0);

        // Start and ready together in IDLE: ready must not advance the pair.
        set_eps(6, 0, 0, 0, 0);
        run_frame(0, 1, 1, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of WRITE after two handshakes.
        set_eps(9, 0, 0, 0, 0);
        frame_num             = FW'(0);
        num_of_history_frames = HW'(1);
        start_write           = 1'b1;
        step();
        start_write = 1'b0;
        expect_out("mid_start", 0, 0);
        handshake(0, 1, 1'b0, 1'b0);
        handshake(1, 1, 1'b0, 1'b0);
        #2 reset_N = 1'b0;
        #1 expect_out("async_reset", 0, 0);
        step();
        reset_N = 1'b1;
        idle_ready(3);

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < NS; i++) end_pointers[i] = AW'($urandom_range(0, 20));
            run_frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                idle_ready(1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
